// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Summary  : Boot-time byte-stream to instruction-memory word writer; holds the
//            core clock enable low until a clean load. Option: IL_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef IWIDTH
`define IWIDTH 32
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module imem_loader #(
    parameter int MAX_WORDS = 256
) (
    input  logic                 il_clk,
    input  logic                 il_rst,
    input  logic                 il_i_start,
    input  logic                 il_i_byte_valid,
    input  logic [7:0]           il_i_byte,
    input  logic                 il_i_byte_last,
    output logic                 il_o_byte_ready,
    output logic                 il_o_wr_en,
    output logic [`PC_WIDTH-1:0] il_o_wr_addr,
    output logic [`IWIDTH-1:0]   il_o_wr_data,
    output logic                 il_o_busy,
    output logic                 il_o_done,
    output logic                 il_o_err,
    output logic                 il_o_core_ce
);
    localparam int DW = `IWIDTH;
    localparam int AW = `PC_WIDTH;
    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam logic [CW-1:0] c_max_words = CW'(MAX_WORDS);
    localparam logic [AW-1:0] c_addr_step = AW'(4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_addr;
    logic [1:0]      r_kidx;
    logic [DW-1:0]   r_buf;
    logic [CW-1:0]   r_word_cnt;
    logic            r_last_seen;
    logic            r_err;
    logic            r_done;
    logic            r_ce;
    logic            r_wr_en;

    logic            w_accept;
    logic            w_word_end;
    logic            w_room;

    assign w_accept = il_i_byte_valid && (r_state == S_RECV);
    assign w_room   = (r_word_cnt != c_max_words);

`ifdef IL_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       w_csum_bad;

    // The last byte is the checksum and never lands in a word.
    assign w_word_end = w_accept && !il_i_byte_last && (r_kidx == 2'd3);
    assign w_csum_bad = (r_kidx != 2'd0) || (il_i_byte != r_sum);

    always_ff @(posedge il_clk or negedge il_rst) begin
        if (!il_rst) begin
            r_sum <= 8'd0;
        end else if ((r_state == S_IDLE || r_state == S_DONE) && il_i_start) begin
            r_sum <= 8'd0;
        end else if (w_accept && !il_i_byte_last) begin
            r_sum <= r_sum + il_i_byte;
        end
    end
`else
    assign w_word_end = w_accept && (il_i_byte_last || (r_kidx == 2'd3));
`endif

    always_ff @(posedge il_clk or negedge il_rst) begin
        if (!il_rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_kidx      <= 2'd0;
            r_buf       <= '0;
            r_word_cnt  <= '0;
            r_last_seen <= 1'b0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_ce        <= 1'b0;
            r_wr_en     <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (il_i_start) begin
                        r_addr      <= '0;
                        r_kidx      <= 2'd0;
                        r_buf       <= '0;
                        r_word_cnt  <= '0;
                        r_last_seen <= 1'b0;
                        r_err       <= 1'b0;
                        r_done      <= 1'b0;
                        r_ce        <= 1'b0;
                        r_state     <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (w_accept) begin
`ifdef IL_CHECKSUM_EN
                        if (il_i_byte_last) begin
                            r_err   <= r_err | w_csum_bad;
                            r_ce    <= !(r_err | w_csum_bad);
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_buf[{r_kidx, 3'b000} +: 8] <= il_i_byte;
                            r_kidx <= r_kidx + 2'd1;
                        end
`else
                        r_buf[{r_kidx, 3'b000} +: 8] <= il_i_byte;
                        r_kidx      <= r_kidx + 2'd1;
                        r_last_seen <= il_i_byte_last;
                        if (il_i_byte_last && (r_kidx != 2'd3)) begin
                            r_err <= 1'b1;
                        end
`endif
                        // Words past capacity still pass through WRITE, but unstrobed.
                        if (w_word_end) begin
                            r_state <= S_WRITE;
                            r_wr_en <= w_room;
                            if (!w_room) begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    r_buf  <= '0;
                    r_kidx <= 2'd0;
                    if (r_wr_en) begin
                        r_addr     <= r_addr + c_addr_step;
                        r_word_cnt <= r_word_cnt + CW'(1);
                    end
                    if (r_last_seen) begin
                        r_done  <= 1'b1;
                        r_ce    <= !r_err;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_RECV;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign il_o_byte_ready = (r_state == S_RECV);
    assign il_o_busy       = (r_state == S_RECV) || (r_state == S_WRITE);
    assign il_o_wr_en      = r_wr_en;
    assign il_o_wr_addr    = r_addr;
    assign il_o_wr_data    = r_buf;
    assign il_o_done       = r_done;
    assign il_o_err        = r_err;
    assign il_o_core_ce    = r_ce;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Summary  : Directed self-checking bench for imem_loader (MAX_WORDS = 2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        bvalid;
    logic [7:0]  bdata;
    logic        blast;
    logic        bready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        core_ce;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] wa [0:31];
    logic [31:0] wd [0:31];
    int nw = 0;
    int base;

    imem_loader #(.MAX_WORDS(2)) dut (
        .il_clk          (clk),
        .il_rst          (rst_n),
        .il_i_start      (start),
        .il_i_byte_valid (bvalid),
        .il_i_byte       (bdata),
        .il_i_byte_last  (blast),
        .il_o_byte_ready (bready),
        .il_o_wr_en      (wr_en),
        .il_o_wr_addr    (wr_addr),
        .il_o_wr_data    (wr_data),
        .il_o_busy       (busy),
        .il_o_done       (done),
        .il_o_err        (err),
        .il_o_core_ce    (core_ce)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en && nw < 32) begin
            wa[nw] = wr_addr;
            wd[nw] = wr_data;
            nw = nw + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        chk({tag, "_addr"},  wr_addr, 32'd0);
        chk({tag, "_data"},  wr_data, 32'd0);
        chk({tag, "_ready"}, {31'd0, bready}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
        chk({tag, "_done"},  {31'd0, done}, 32'd0);
        chk({tag, "_err"},   {31'd0, err}, 32'd0);
        chk({tag, "_ce"},    {31'd0, core_ce}, 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present one byte and hold it until the loader takes it.
    task automatic send(input logic [7:0] b, input logic last);
        int n = 0;
        bvalid = 1'b1;
        bdata  = b;
        blast  = last;
        while (!bready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_ready", {31'd0, bready}, 32'd1);
        @(posedge clk); #1;
        bvalid = 1'b0;
        blast  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        bvalid = 1'b0;
        bdata  = 8'h00;
        blast  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Start then abort mid-word with asynchronous reset.
        pulse_start();
        chk("start_ready", {31'd0, bready}, 32'd1);
        chk("start_busy",  {31'd0, busy}, 32'd1);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef IL_CHECKSUM_EN
        // Good checksum: 1+2+3+4 = 0x0A.
        pulse_start();
        base = nw;
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
        send(8'h0A, 1'b1);
        wait_done();
        chk("cs_nwr",   nw - base, 32'd1);
        chk("cs_addr",  wa[base], 32'h0);
        chk("cs_data",  wd[base], 32'h04030201);
        chk("cs_err",   {31'd0, err}, 32'd0);
        chk("cs_ce",    {31'd0, core_ce}, 32'd1);

        // Bad checksum.
        pulse_start();
        chk("cs_restart_ce",   {31'd0, core_ce}, 32'd0);
        chk("cs_restart_done", {31'd0, done}, 32'd0);
        base = nw;
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
        send(8'h0B, 1'b1);
        wait_done();
        chk("csbad_nwr",  nw - base, 32'd1);
        chk("csbad_data", wd[base], 32'h04030201);
        chk("csbad_err",  {31'd0, err}, 32'd1);
        chk("csbad_ce",   {31'd0, core_ce}, 32'd0);
`else
        // Basic two-word load starting at address 0.
        pulse_start();
        base = nw;
        send(8'h13, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        send(8'h20, 1'b0); send(8'h08, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b1);
        wait_done();
        chk("basic_nwr",   nw - base, 32'd2);
        chk("basic_addr0", wa[base], 32'h0);
        chk("basic_data0", wd[base], 32'h00000013);
        chk("basic_addr1", wa[base+1], 32'h4);
        chk("basic_data1", wd[base+1], 32'h00000820);
        chk("basic_err",   {31'd0, err}, 32'd0);
        chk("basic_ce",    {31'd0, core_ce}, 32'd1);
        chk("basic_busy",  {31'd0, busy}, 32'd0);

        // Partial final word.
        pulse_start();
        chk("restart_ce",   {31'd0, core_ce}, 32'd0);
        chk("restart_done", {31'd0, done}, 32'd0);
        base = nw;
        send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0);
        send(8'hEE, 1'b1);
        wait_done();
        chk("part_nwr",   nw - base, 32'd2);
        chk("part_data0", wd[base], 32'hDDCCBBAA);
        chk("part_addr1", wa[base+1], 32'h4);
        chk("part_data1", wd[base+1], 32'h000000EE);
        chk("part_err",   {31'd0, err}, 32'd1);
        chk("part_ce",    {31'd0, core_ce}, 32'd0);

        // Valid held across the WRITE cycle.
        pulse_start();
        base = nw;
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
        chk("bp_wr_en", {31'd0, wr_en}, 32'd1);
        chk("bp_ready", {31'd0, bready}, 32'd0);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0); send(8'h77, 1'b0); send(8'h88, 1'b1);
        wait_done();
        chk("bp_nwr",   nw - base, 32'd2);
        chk("bp_data0", wd[base], 32'h04030201);
        chk("bp_data1", wd[base+1], 32'h88776655);
        chk("bp_err",   {31'd0, err}, 32'd0);
        chk("bp_ce",    {31'd0, core_ce}, 32'd1);

        // Third word exceeds capacity of two.
        pulse_start();
        base = nw;
        for (int i = 0; i < 12; i++) begin
            send(8'(i), (i == 11));
        end
        wait_done();
        chk("ovf_nwr",   nw - base, 32'd2);
        chk("ovf_addr0", wa[base], 32'h0);
        chk("ovf_data0", wd[base], 32'h03020100);
        chk("ovf_addr1", wa[base+1], 32'h4);
        chk("ovf_data1", wd[base+1], 32'h07060504);
        chk("ovf_err",   {31'd0, err}, 32'd1);
        chk("ovf_ce",    {31'd0, core_ce}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
